// File: rtl/dp_run_ctrl_if.sv
// Board-side bundle for the datapath run/step controller.
// The controller takes the slave view; the board top takes the master view.
interface dp_run_ctrl_if #(
  parameter int unsigned CW = 16
);
  logic          run_sw;
  logic          step_btn;
  logic [159:0]  regs;
  logic          dp_en;
  logic [1:0]    state;
  logic [CW-1:0] cycle_cnt;
  logic          pass;
  logic          fail;

  modport master (
    output run_sw, step_btn, regs,
    input  dp_en, state, cycle_cnt, pass, fail
  );

  modport slave (
    input  run_sw, step_btn, regs,
    output dp_en, state, cycle_cnt, pass, fail
  );
endinterface

// File: rtl/dp_run_ctrl.sv
// Run/step controller: issues one-cycle datapath advance enables and
// halts the datapath on a matching result signature or on timeout.
module dp_run_ctrl #(
  parameter int unsigned DIV     = 1000000,
  parameter int unsigned DB      = 100000,
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned CW      = 16,
  parameter logic [31:0] EXP0    = 32'h0e,
  parameter logic [31:0] EXP1    = 32'h0d,
  parameter logic [31:0] EXP2    = 32'h0d,
  parameter logic [31:0] EXP3    = 32'h0f,
  parameter logic [31:0] EXP4    = 32'h50
) (
  input  logic      clk_pre,
  input  logic      reset,
  dp_run_ctrl_if.slave bus
);

  localparam int unsigned TW  = $clog2(DIV);
  localparam int unsigned DBW = $clog2(DB + 1);

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    FAIL = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic           en_q, en_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [TW-1:0]  tcnt_q, tcnt_d;
  logic [1:0]     sync_q;
  logic           db_q, db_d;
  logic           dbp_q;
  logic [DBW-1:0] dbc_q, dbc_d;

  logic tick;
  logic step_ev;
  logic fwd;
  logic rev;
  logic match;
  logic tmo;

  assign tick   = (tcnt_q == TW'(DIV - 1));
  assign tcnt_d = tick ? '0 : tcnt_q + TW'(1);

  // Debounce: adopt the synced level once it has differed DB cycles in a row
  always_comb begin
    dbc_d = '0;
    db_d  = db_q;
    if (sync_q[1] != db_q) begin
      if (dbc_q == DBW'(DB - 1)) begin
        db_d = sync_q[1];
      end else begin
        dbc_d = dbc_q + DBW'(1);
      end
    end
  end

  assign step_ev = db_q & ~dbp_q;

  assign fwd = (bus.regs[31:0]    == EXP0) &&
               (bus.regs[63:32]   == EXP1) &&
               (bus.regs[95:64]   == EXP2) &&
               (bus.regs[127:96]  == EXP3) &&
               (bus.regs[159:128] == EXP4);
  assign rev = (bus.regs[31:0]    == EXP4) &&
               (bus.regs[63:32]   == EXP3) &&
               (bus.regs[95:64]   == EXP2) &&
               (bus.regs[127:96]  == EXP1) &&
               (bus.regs[159:128] == EXP0);
  assign match = fwd | rev;
  assign tmo   = (cnt_q == CW'(TIMEOUT));

  always_comb begin
    state_d = state_q;
    en_d    = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      HOLD: begin
        if (match) begin
          state_d = DONE;
        end else if (tmo) begin
          state_d = FAIL;
        end else if (bus.run_sw) begin
          state_d = RUN;
        end else if (step_ev) begin
          en_d  = 1'b1;
          cnt_d = cnt_q + CW'(1);
        end
      end
      RUN: begin
        if (match) begin
          state_d = DONE;
        end else if (tmo) begin
          state_d = FAIL;
        end else if (!bus.run_sw) begin
          state_d = HOLD;
        end else if (tick) begin
          en_d  = 1'b1;
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  always_ff @(posedge clk_pre) begin
    if (reset) begin
      state_q <= HOLD;
      en_q    <= 1'b0;
      cnt_q   <= '0;
      tcnt_q  <= '0;
      sync_q  <= 2'b00;
      db_q    <= 1'b0;
      dbp_q   <= 1'b0;
      dbc_q   <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      sync_q  <= {sync_q[0], bus.step_btn};
      db_q    <= db_d;
      dbp_q   <= db_q;
      dbc_q   <= dbc_d;
    end
  end

  assign bus.dp_en     = en_q;
  assign bus.state     = state_q;
  assign bus.cycle_cnt = cnt_q;
  assign bus.pass      = (state_q == DONE);
  assign bus.fail      = (state_q == FAIL);

endmodule

// File: tb/tb_dp_run_ctrl.sv
// Bench for dp_run_ctrl: directed scenarios plus a random phase,
// all checked against a cycle-level behavioural model.
module tb_dp_run_ctrl;

  localparam int DIV     = 4;
  localparam int DB      = 3;
  localparam int TIMEOUT = 10;
  localparam int CW      = 16;

  localparam logic [31:0] EXPV [5] = '{32'h0e, 32'h0d, 32'h0d, 32'h0f, 32'h50};
  localparam logic [159:0] MFWD = {32'h50, 32'h0f, 32'h0d, 32'h0d, 32'h0e};
  localparam logic [159:0] MREV = {32'h0e, 32'h0d, 32'h0d, 32'h0f, 32'h50};

  logic clk;
  logic rst;

  dp_run_ctrl_if #(.CW(CW)) bus ();

  dp_run_ctrl #(
    .DIV(DIV),
    .DB(DB),
    .TIMEOUT(TIMEOUT),
    .CW(CW)
  ) dut (
    .clk_pre(clk),
    .reset(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int ncall    = 0;
  bit obs_en;

  // model state: values the DUT should show after the next edge
  int m_state;
  int m_cnt;
  int m_cyc;
  int m_run;
  bit m_en;
  bit m_db;
  bit m_dbp;
  bit hist[$];

  function automatic bit is_match(logic [159:0] r);
    bit f = 1'b1;
    bit b = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (r[32*k +: 32] !== EXPV[k])     f = 1'b0;
      if (r[32*k +: 32] !== EXPV[4 - k]) b = 1'b0;
    end
    return f | b;
  endfunction

  function automatic logic [159:0] rnd_regs();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic model_edge(bit r, bit run, bit btn, logic [159:0] rg);
    bit tick;
    bit sync;
    bit sev;
    bit pulse;
    if (r) begin
      m_state = 0; m_cnt = 0; m_cyc = 0; m_run = 0;
      m_en = 0; m_db = 0; m_dbp = 0;
      hist.delete();
      return;
    end
    tick  = ((m_cyc % DIV) == DIV - 1);
    sync  = (hist.size() == 2) ? hist[0] : 1'b0;
    sev   = m_db && !m_dbp;
    pulse = 1'b0;
    if (m_state == 0 || m_state == 1) begin
      if (is_match(rg))           m_state = 2;
      else if (m_cnt == TIMEOUT)  m_state = 3;
      else if (m_state == 0) begin
        if (run)      m_state = 1;
        else if (sev) pulse = 1'b1;
      end else begin
        if (!run)      m_state = 0;
        else if (tick) pulse = 1'b1;
      end
    end
    m_en = pulse;
    if (pulse) m_cnt++;
    m_dbp = m_db;
    if (sync != m_db) begin
      m_run++;
      if (m_run == DB) begin
        m_db  = sync;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    hist.push_back(btn);
    if (hist.size() > 2) void'(hist.pop_front());
    m_cyc++;
  endtask

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(bit r, bit run, bit btn, logic [159:0] rg);
    @(negedge clk);
    ncall++;
    obs_en = bus.dp_en;
    chk("state", 32'(bus.state), 32'(m_state));
    chk("dp_en", 32'(bus.dp_en), 32'(m_en));
    chk("cycle_cnt", 32'(bus.cycle_cnt), 32'(m_cnt));
    chk("pass", 32'(bus.pass), 32'(m_state == 2));
    chk("fail", 32'(bus.fail), 32'(m_state == 3));
    rst          = r;
    bus.run_sw   = run;
    bus.step_btn = btn;
    bus.regs     = rg;
    model_edge(r, run, btn, rg);
  endtask

  initial begin
    int last;
    int npul;
    int settle;
    int first;
    int k;
    bit run;
    bit btn;
    logic [159:0] rg;
    bit bpat [8] = '{1, 1, 0, 0, 1, 1, 0, 0};

    rst = 1'b1;
    bus.run_sw = 1'b0;
    bus.step_btn = 1'b0;
    bus.regs = rnd_regs();
    model_edge(1'b1, 1'b0, 1'b0, bus.regs);

    // reset values
    step(1, 0, 0, rnd_regs());
    chk("rst_state", 32'(bus.state), 0);
    chk("rst_cnt", 32'(bus.cycle_cnt), 0);
    chk("rst_en", 32'(bus.dp_en), 0);

    // free run: period DIV
    last = -1;
    for (int i = 0; i < 24; i++) begin
      step(0, 1, 0, rnd_regs());
      if (obs_en) begin
        if (last >= 0) chk("run_period", ncall - last, DIV);
        last = ncall;
      end
    end
    chk("run_state", 32'(bus.state), 1);

    // single step with bounce
    step(1, 0, 0, rnd_regs());
    npul = 0;
    first = -1;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, bpat[i], rnd_regs());
      if (obs_en) npul++;
    end
    settle = ncall + 1;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, (i < 10), rnd_regs());
      if (obs_en) begin
        npul++;
        if (first < 0) first = ncall;
      end
    end
    chk("step_pulses", npul, 1);
    chk("step_latency", first - settle, DB + 3);
    chk("step_cnt", 32'(bus.cycle_cnt), 1);

    // button held through reset
    step(1, 0, 1, rnd_regs());
    step(1, 0, 1, rnd_regs());
    npul = 0;
    for (int i = 0; i < 14; i++) begin
      step(0, 0, 1, rnd_regs());
      if (obs_en) npul++;
    end
    chk("held_rst_pulses", npul, 1);

    // match forward then reversed, separate runs
    for (int m = 0; m < 2; m++) begin
      rg = (m == 0) ? MFWD : MREV;
      step(1, 1, 0, rnd_regs());
      for (int i = 0; i < 9; i++) step(0, 1, 0, rnd_regs());
      step(0, 1, 0, rg);
      step(0, 1, 0, rg);
      chk("match_state", 32'(bus.state), 2);
      chk("match_pass", 32'(bus.pass), 1);
      npul = 0;
      for (int i = 0; i < 10; i++) begin
        step(0, 1, 1, rnd_regs());
        if (obs_en) npul++;
      end
      chk("done_pulses", npul, 0);
    end

    // timeout
    step(1, 1, 0, rnd_regs());
    npul = 0;
    k = 0;
    while (!bus.fail && k < 80) begin
      step(0, 1, 0, rnd_regs());
      if (obs_en) npul++;
      k++;
    end
    chk("tmo_reached", 32'(bus.fail), 1);
    chk("tmo_pulses", npul, TIMEOUT);
    chk("tmo_cnt", 32'(bus.cycle_cnt), TIMEOUT);
    for (int i = 0; i < 8; i++) step(0, 1, 0, rnd_regs());

    // match and timeout together
    step(1, 1, 0, rnd_regs());
    k = 0;
    while (m_cnt != TIMEOUT && k < 80) begin
      step(0, 1, 0, rnd_regs());
      k++;
    end
    chk("mt_bound", 32'(m_cnt), TIMEOUT);
    step(0, 1, 0, MFWD);
    step(0, 1, 0, rnd_regs());
    chk("mt_state", 32'(bus.state), 2);

    // run_sw falls on tick
    step(1, 1, 0, rnd_regs());
    k = 0;
    while (!(m_state == 1 && (m_cyc % DIV) == DIV - 1 && m_cyc > 4) && k < 20) begin
      step(0, 1, 0, rnd_regs());
      k++;
    end
    step(0, 0, 0, rnd_regs());
    step(0, 0, 0, rnd_regs());
    chk("fall_en", 32'(bus.dp_en), 0);
    chk("fall_state", 32'(bus.state), 0);

    // step press in RUN
    step(1, 1, 0, rnd_regs());
    npul = 0;
    for (int i = 0; i < 24; i++) begin
      step(0, 1, (i >= 2 && i < 14), rnd_regs());
      if (obs_en) npul++;
    end
    chk("run_btn_pulses", npul, 5);

    // reset mid-run
    for (int i = 0; i < 6; i++) step(0, 1, 0, rnd_regs());
    step(1, 1, 0, rnd_regs());
    step(0, 1, 0, rnd_regs());
    chk("rr_state", 32'(bus.state), 0);
    chk("rr_cnt", 32'(bus.cycle_cnt), 0);
    chk("rr_en", 32'(bus.dp_en), 0);
    settle = ncall;
    first = -1;
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 0, rnd_regs());
      if (obs_en && first < 0) first = ncall;
    end
    chk("rr_first", first - settle, DIV);

    // reset from DONE
    step(0, 1, 0, MREV);
    step(0, 1, 0, rnd_regs());
    chk("rd_done", 32'(bus.state), 2);
    step(1, 1, 0, rnd_regs());
    step(0, 0, 0, rnd_regs());
    chk("rd_state", 32'(bus.state), 0);
    chk("rd_pass", 32'(bus.pass), 0);

    // random phase
    run = 1'b0;
    btn = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(9) == 0) run = ~run;
      if ($urandom_range(11) == 0) btn = ~btn;
      k = $urandom_range(199);
      rg = (k == 0) ? MFWD : (k == 1) ? MREV : rnd_regs();
      step(($urandom_range(99) == 0), run, btn, rg);
    end
    step(0, 0, 0, rnd_regs());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
